// File: rtl/dbg_trace_reader.sv
// rtl/dbg_trace_reader.sv - trigger-armed probe capture ring with MSB-first byte-stream readout
module dbg_trace_reader #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trig_in,
    input  logic              probe_valid,
    input  logic [DATA_W-1:0] probe_data,
    output logic              busy,
    output logic              triggered,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NB     = DATA_W / 8;
    localparam int BW     = (NB > 1) ? $clog2(NB) : 1;
    localparam int POST_N = DEPTH - PRE_TRIG;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;        // prefetched word, waiting to enter wbuf
    logic [DATA_W-1:0] wbuf;        // word being shifted out, current byte on top
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_addr;     // loaded with the oldest retained address at trigger
    logic [AW-1:0]     pre_cnt;
    logic [AW-1:0]     post_cnt;
    logic [AW:0]       fetch_cnt;   // words read from RAM this readout
    logic [AW:0]       load_cnt;    // words moved into wbuf this readout
    logic [BW-1:0]     bidx;
    logic              nxt_valid;
    logic              wbuf_valid;
    logic              trig_q;

    logic wr_en, trig_hit, accept, last_byte, word_done, load, issue, final_word;

    // Next-state, write qualification and readout pipeline control
    always_comb begin
        state_d    = state_q;
        wr_en      = probe_valid && (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST);
        trig_hit   = wr_en && trig_in && (state_q == S_WAIT);
        accept     = wbuf_valid && m_ready;
        last_byte  = (bidx == BW'(NB - 1));
        word_done  = accept && last_byte;
        final_word = (load_cnt == (AW+1)'(DEPTH));
        load       = (state_q == S_READ) && nxt_valid && (!wbuf_valid || word_done);
        issue      = (state_q == S_READ) && (fetch_cnt != (AW+1)'(DEPTH)) && (!nxt_valid || load);
        case (state_q)
            S_IDLE: if (arm) state_d = S_PRE;
            S_PRE:  if (wr_en && pre_cnt == AW'(PRE_TRIG - 1)) state_d = S_WAIT;
            S_WAIT: if (trig_hit) state_d = (POST_N == 1) ? S_READ : S_POST;
            S_POST: if (wr_en && post_cnt == AW'(POST_N - 1)) state_d = S_READ;
            S_READ: if (word_done && final_word) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign triggered = trig_q;
    assign m_valid   = wbuf_valid;
    assign m_data    = wbuf[DATA_W-1 -: 8];
    assign m_last    = wbuf_valid && last_byte && final_word;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Capture RAM: one write port, registered read used only when a fetch is issued
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= probe_data;
        if (issue) rd_q <= mem[rd_addr];
    end

    // Pointers, counters, trigger flag and the two-word readout buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_addr    <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            fetch_cnt  <= '0;
            load_cnt   <= '0;
            bidx       <= '0;
            nxt_valid  <= 1'b0;
            wbuf_valid <= 1'b0;
            wbuf       <= '0;
            trig_q     <= 1'b0;
        end else begin
            if (state_q == S_IDLE && arm) begin
                pre_cnt  <= '0;
                post_cnt <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state_q == S_PRE)  pre_cnt  <= pre_cnt + 1'b1;
                if (state_q == S_POST) post_cnt <= post_cnt + 1'b1;
            end
            // The trigger sample lands at wr_ptr, so the oldest retained sample
            // is PRE_TRIG slots behind it; modulo wrap comes from the width.
            if (trig_hit) begin
                post_cnt <= AW'(1);
                rd_addr  <= wr_ptr - AW'(PRE_TRIG);
                trig_q   <= 1'b1;
            end
            if (issue) begin
                rd_addr   <= rd_addr + 1'b1;
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            nxt_valid <= issue || (nxt_valid && !load);
            if (load) begin
                wbuf       <= rd_q;
                wbuf_valid <= 1'b1;
                bidx       <= '0;
                load_cnt   <= load_cnt + 1'b1;
            end else if (accept) begin
                wbuf <= wbuf << 8;
                bidx <= bidx + 1'b1;
                if (last_byte) wbuf_valid <= 1'b0;
            end
            if (state_q == S_READ && state_d == S_IDLE) begin
                trig_q     <= 1'b0;
                fetch_cnt  <= '0;
                load_cnt   <= '0;
                nxt_valid  <= 1'b0;
                wbuf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dbg_trace_reader.sv
// tb/tb_dbg_trace_reader.sv - randomized and directed bench for dbg_trace_reader against a sample-list model
module tb_dbg_trace_reader;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;
    localparam int POST_N   = DEPTH - PRE_TRIG;
    localparam int NB       = DATA_W / 8;
    localparam int TOTAL    = DEPTH * NB;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              trig_in;
    logic              probe_valid;
    logic [DATA_W-1:0] probe_data;
    logic              busy;
    logic              triggered;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    int checks = 0;
    int errors = 0;

    dbg_trace_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_in(trig_in),
        .probe_valid(probe_valid), .probe_data(probe_data),
        .busy(busy), .triggered(triggered),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; arm = 1'b0; probe_valid = 1'b0; trig_in = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_triggered"}, triggered, 1'b0);
        check({tag, "_m_valid"},   m_valid,   1'b0);
        check({tag, "_m_last"},    m_last,    1'b0);
        check({tag, "_m_data"},    m_data,    8'h00);
        rst = 1'b0;
    endtask

    // vmode: 0 always valid, 1 every 3rd cycle, 2 random
    // tmode: 0 trig when data==tval, 1 trig always high, 2 random
    // rmode: 0 always ready, 1 pattern 1-0-0-1, 2 random
    // dmode: 0 counting data (advances per stored sample), 1 random
    // abort: 0 none, 1 reset during POST, 2 reset after 10 bytes read
    task automatic run_capture(input int vmode, input int tmode, input int tval,
                               input int rmode, input int dmode, input int abort);
        logic [DATA_W-1:0] samples[$];
        logic [7:0]        exp_bytes[$];
        logic [DATA_W-1:0] ctr = '0;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] w;
        logic [7:0]        prev_data = '0;
        logic              prev_last = 1'b0;
        bit                pv, tg, rdy, done = 0, prev_stall = 0;
        int                trig_idx = -1, cyc = 0, n = 0, first = -1;

        arm = 1'b1; probe_valid = 1'b0; trig_in = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
        check("busy_after_arm", busy, 1'b1);

        while (!done && cyc < 3000) begin
            pv = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
            d  = (dmode == 0) ? ctr : DATA_W'($urandom);
            tg = (tmode == 0) ? (d == DATA_W'(tval)) : (tmode == 1) ? 1'b1 : ($urandom_range(0, 7) == 0);
            probe_valid = pv; probe_data = d; trig_in = tg;
            if (pv) begin
                if (dmode == 0) ctr++;
                if (trig_idx < 0 && samples.size() >= PRE_TRIG && tg) trig_idx = samples.size();
                samples.push_back(d);
                if (trig_idx >= 0 && samples.size() == trig_idx + POST_N) done = 1;
            end
            @(posedge clk); #1;
            cyc++;
            check("busy_capture", busy, 1'b1);
            check("triggered_flag", triggered, trig_idx >= 0);
            if (abort == 1 && trig_idx >= 0 && samples.size() == trig_idx + 3) begin
                do_reset("rst_post");
                return;
            end
        end
        if (!done) begin
            check("capture_timeout", 1'b0, 1'b1);
            return;
        end

        for (int i = trig_idx - PRE_TRIG; i < trig_idx + POST_N; i++) begin
            w = samples[i];
            for (int k = 0; k < NB; k++) exp_bytes.push_back(w[DATA_W-1-8*k -: 8]);
        end

        cyc = 0;
        while (n < TOTAL && cyc < 2000) begin
            if (abort == 2 && n == 10) begin
                do_reset("rst_read");
                return;
            end
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            m_ready     = rdy;
            probe_valid = 1'($urandom_range(0, 1));
            probe_data  = DATA_W'($urandom);
            trig_in     = 1'($urandom_range(0, 1));
            arm         = ($urandom_range(0, 7) == 0);
            if (m_valid) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_valid_latency", first <= 2, 1'b1);
                end
                if (prev_stall) begin
                    check("stall_data", m_data, prev_data);
                    check("stall_last", m_last, prev_last);
                end
                if (rdy) begin
                    check($sformatf("byte%0d", n), m_data, exp_bytes[n]);
                    check("m_last_flag", m_last, n == TOTAL - 1);
                    if (n == TOTAL - 1) arm = 1'b1;
                    n++;
                end
                prev_stall = !rdy;
                prev_data  = m_data;
                prev_last  = m_last;
            end else begin
                if (prev_stall) check("valid_dropped_while_stalled", 1'b0, 1'b1);
                prev_stall = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        arm = 1'b0; probe_valid = 1'b0; trig_in = 1'b0; m_ready = 1'b0;
        check("readout_count", n, TOTAL);
        check("done_busy",      busy,      1'b0);
        check("done_triggered", triggered, 1'b0);
        check("done_m_valid",   m_valid,   1'b0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig_in = 1'b0; probe_valid = 1'b0;
        probe_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",      busy,      1'b0);
        check("reset_triggered", triggered, 1'b0);
        check("reset_m_valid",   m_valid,   1'b0);
        check("reset_m_last",    m_last,    1'b0);
        check("reset_m_data",    m_data,    8'h00);
        rst = 1'b0;

        run_capture(0, 0, 20, 0, 0, 0);   // trigger on value 20
        run_capture(0, 1, 0,  0, 0, 0);   // trigger held high from arm
        run_capture(0, 0, 97, 0, 0, 0);   // ring wraps several times before trigger
        run_capture(0, 0, 20, 1, 0, 0);   // backpressure 1-0-0-1
        run_capture(1, 0, 20, 0, 0, 0);   // probe_valid every 3rd cycle
        run_capture(0, 0, 20, 0, 0, 1);   // reset in POST
        run_capture(0, 0, 20, 2, 0, 2);   // reset mid-readout
        run_capture(0, 0, 20, 0, 0, 0);   // clean capture after aborts
        for (int r = 0; r < 4; r++) run_capture(2, 2, 0, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_trace_reader.md
Name: dbg_trace_reader

Overview:
- Trigger-armed capture buffer for on-chip debug of the imx_face_udp datapath.
- Records a probe word into an internal ring RAM around a trigger event.
- Then reads the capture back out as a byte stream with valid/ready handshake, so the UDP transmit path can ship it to the host.
- It is the readout end of the probe-capture path: probes go in, and this block brings the samples back out.

Parameters:
- DATA_W, 32, probe word width in bits; must be a multiple of 8, range 8..256.
- DEPTH, 256, capture depth in samples; power of 2, at least 4.
- PRE_TRIG, 64, samples kept before the trigger; range 1..DEPTH-1.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse that starts a capture; honoured only in IDLE.
- trig_in  in  1  trigger condition, sampled only when probe_valid=1.
- probe_valid  in  1  qualifies probe_data; a sample is written only when high.
- probe_data  in  DATA_W  word to capture.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  high from the trigger sample until return to IDLE.
- m_data  out  8  readout byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the byte.
- m_last  out  1  marks the final byte of the capture, qualified by m_valid.

Behaviour:
- Reset: state=IDLE; busy, triggered, m_valid, m_last = 0; m_data = 0; write pointer = 0; all counters = 0. RAM contents are don't-care.
- The same behaviour applies to reset asserted mid-capture or mid-readout: the transfer is aborted, and no m_last is produced.
- States:
  - IDLE --arm--> PRE
  - PRE --PRE_TRIG samples written--> WAIT
  - WAIT --probe_valid & trig_in--> POST
  - POST --(DEPTH-PRE_TRIG) samples written, trigger sample included--> READ
  - READ --last byte accepted--> IDLE
- Writes: in PRE, WAIT and POST, each cycle with probe_valid=1 writes probe_data at wr_ptr, then wr_ptr = (wr_ptr+1) mod DEPTH. Cycles with probe_valid=0 write nothing and advance no counter.
- PRE:
  - trig_in is ignored, so a pre-trigger window never holds fewer than PRE_TRIG samples.
  - PRE_TRIG writes are complete on the cycle of the PRE_TRIG-th write; the next state is WAIT.
- WAIT: the ring overwrites continuously. The trigger sample is written in the same cycle the state enters POST, and triggered rises the next cycle. trig_ptr records the address of the trigger sample.
- POST: trig_in is ignored. Exactly DEPTH-PRE_TRIG writes occur, counting the trigger sample. If PRE_TRIG = DEPTH-1, the trigger sample alone completes POST.
- READ:
  - Start address = (trig_ptr - PRE_TRIG) mod DEPTH, i.e. the oldest retained sample. Pointer arithmetic is log2(DEPTH) bits and wraps naturally.
  - Words are read oldest first, DEPTH words in total. Bytes within a word are sent MSB first: byte k = data[DATA_W-1-8k -: 8].
  - Total bytes = DEPTH*DATA_W/8. m_last=1 only on the final byte.
  - RAM read latency is 1 cycle. First m_valid comes no later than 2 cycles after entering READ.
  - Prefetching is allowed, but no bubbles once streaming while m_ready=1: one byte per cycle.
- Handshake:
  - A byte transfers when m_valid & m_ready.
  - Once m_valid is high, m_data, m_last and m_valid hold stable until accepted.
  - m_valid does not depend combinationally on m_ready.
- Simultaneous / ignored events:
  - arm outside IDLE is ignored.
  - arm in the cycle READ ends is ignored, because the state is still READ.
  - probe_valid/trig_in during READ are ignored and not written.
- After the last byte is accepted: busy=0, triggered=0, m_valid=0 on the next cycle.

Test Plan:
1. DATA_W=32, DEPTH=16, PRE_TRIG=4. Arm, probe_valid=1 every cycle with data=0,1,2,… and trig_in high on the sample with value 20. Expect 64 bytes for words 16..31, first bytes 00 00 00 10, m_last on byte 63 (value 0x1F), then busy=0.
2. Same setup, trig_in held high from arm onward. Expect the trigger to be taken on the 5th sample (value 4), and readout of words 0..15.
3. Trigger late, so the ring wraps more than once before trig: values 0..99 with trig at 97. Expect readout of words 93..108, with the start address computed correctly across the wrap.
4. Backpressure: m_ready toggling 1-0-0-1 during readout. Expect data stable while stalled, no byte lost or duplicated, and 64 transfers total.
5. probe_valid gaps (high every 3rd cycle). Expect only qualified samples stored, and the sample sequence contiguous in the readout.
6. rst asserted during POST and again during READ at byte 10. Expect all outputs 0 the next cycle, state IDLE, and a subsequent arm giving a correct full capture.
